// File: rtl/muldiv_ctrl_if.sv
// Operation bus between the EX stage and the multiply sequencer.
// Signal prefixes are from the sequencer's point of view.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   i_op_valid;
    logic [2:0]             i_op;
    logic [WIDTH-1:0]       i_rs_val;
    logic [WIDTH-1:0]       i_rt_val;
    logic                   i_flush;
    logic                   o_stall;
    logic                   o_busy;
    logic [1:0]             o_hilo_mode;
    logic [2*WIDTH-1:0]     o_product;

    modport master (
        output i_op_valid, i_op, i_rs_val, i_rt_val, i_flush,
        input  o_stall, o_busy, o_hilo_mode, o_product
    );

    modport slave (
        input  i_op_valid, i_op, i_rs_val, i_rt_val, i_flush,
        output o_stall, o_busy, o_hilo_mode, o_product
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply sequencer: 32-iteration shift-add multiplier that issues a
// one-cycle load/accumulate command to HiLo and stalls EX while it is busy.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    muldiv_ctrl_if.slave    bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MADDU = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_is_mul;
    logic                   w_sign;
    logic [WIDTH-1:0]       w_rs_mag;
    logic [WIDTH-1:0]       w_rt_mag;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_acc_sum;
    logic [2*WIDTH-1:0]     w_final;

    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mlt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_count;
    logic                   r_neg;
    logic                   r_madd;
    logic                   r_busy;
    logic [1:0]             r_mode;
    logic [2*WIDTH-1:0]     r_product;

    // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    assign w_is_mul  = (bus.i_op == OP_MULTU) || (bus.i_op == OP_MULT) || (bus.i_op == OP_MADDU);
    assign w_rs_mag  = magnitude(bus.i_rs_val, bus.i_op == OP_MULT);
    assign w_rt_mag  = magnitude(bus.i_rt_val, bus.i_op == OP_MULT);
    assign w_sign    = (bus.i_op == OP_MULT) && (bus.i_rs_val[WIDTH-1] ^ bus.i_rt_val[WIDTH-1]);
    assign w_addend  = r_mlt[0] ? r_mcand : {(2*WIDTH){1'b0}};
    assign w_acc_sum = r_acc + w_addend;
    assign w_final   = r_neg ? (~w_acc_sum + (2*WIDTH)'(1)) : w_acc_sum;

    // Stall is combinational so a held op is released in the first IDLE cycle.
    assign bus.o_stall     = bus.i_op_valid && (r_state != S_IDLE);
    assign bus.o_busy      = r_busy;
    assign bus.o_hilo_mode = r_mode;
    assign bus.o_product   = r_product;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode; w_last marks the final iteration that produces the result.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_op_valid && !bus.i_flush && w_is_mul) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.i_flush) begin
                    w_state_nx = S_IDLE;
                end else if (r_count == LAST) begin
                    w_last     = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_RUN;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Shift-add datapath; the multiplicand register shifts instead of using a barrel shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= {(2*WIDTH){1'b0}};
            r_mlt   <= {WIDTH{1'b0}};
            r_acc   <= {(2*WIDTH){1'b0}};
            r_count <= {CW{1'b0}};
            r_neg   <= 1'b0;
            r_madd  <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, w_rs_mag};
            r_mlt   <= w_rt_mag;
            r_acc   <= {(2*WIDTH){1'b0}};
            r_count <= {CW{1'b0}};
            r_neg   <= w_sign;
            r_madd  <= (bus.i_op == OP_MADDU);
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_sum;
            r_mcand <= r_mcand << 1;
            r_mlt   <= r_mlt >> 1;
            r_count <= r_count + CW'(1);
        end else begin
            r_acc   <= r_acc;
        end
    end

    // Registered outputs: busy follows the next state, the HiLo command is live only in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_mode    <= 2'b00;
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            if (w_last) begin
                r_mode    <= r_madd ? 2'b10 : 2'b01;
                r_product <= w_final;
            end else begin
                r_mode    <= 2'b00;
                r_product <= {(2*WIDTH){1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops against an
// arithmetic reference model, and hand-written stall/flush/reset sequences.
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(W)) bus();
    muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic [1:0]  mode;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 3'b010) return 64'(sa * sb);
        return 64'(ua * ub);
    endfunction

    function automatic logic [1:0] ref_mode(input logic [2:0] op);
        return (op == 3'b011) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_op_valid = v;
        bus.i_op       = op;
        bus.i_rs_val   = a;
        bus.i_rt_val   = b;
    endtask

    // Called at the negedge of the first RUN cycle; checks W+1 busy cycles and the single DONE pulse.
    task automatic expect_run(input logic [63:0] p, input logic [1:0] m, input logic exp_stall, input string tag);
        for (int c = 0; c <= W; c++) begin
            #1;
            chk({tag, " busy"}, 64'(bus.o_busy), 64'd1);
            chk({tag, " stall"}, 64'(bus.o_stall), 64'(exp_stall));
            chk({tag, " mode"}, 64'(bus.o_hilo_mode), (c == W) ? 64'(m) : 64'd0);
            chk({tag, " product"}, bus.o_product, (c == W) ? p : 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        @(negedge clk);
        drive(1'b1, v.op, v.a, v.b);
        #1 chk({tag, " stall_idle"}, 64'(bus.o_stall), 64'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        expect_run(v.prod, v.mode, 1'b0, tag);
        #1;
        chk({tag, " busy_after"}, 64'(bus.o_busy), 64'd0);
        chk({tag, " mode_after"}, 64'(bus.o_hilo_mode), 64'd0);
    endtask

    initial begin
        vec_t v;
        reset       = 1'b1;
        bus.i_flush = 1'b0;
        drive(1'b1, 3'b001, 32'd5, 32'd7);
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 64'(bus.o_stall), 64'd0);
        chk("reset busy", 64'(bus.o_busy), 64'd0);
        chk("reset mode", 64'(bus.o_hilo_mode), 64'd0);
        chk("reset product", bus.o_product, 64'd0);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 chk("post-reset busy", 64'(bus.o_busy), 64'd0);

        vecs[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2'b01};
        vecs[1] = '{3'b010, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 2'b01};
        vecs[2] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2'b01};
        vecs[3] = '{3'b011, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 2'b10};
        vecs[4] = '{3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 2'b01};
        vecs[5] = '{3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 2'b01};
        vecs[6] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2'b01};
        vecs[7] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 2'b10};
        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            v.op   = 3'($urandom_range(1, 3));
            v.a    = pick_operand();
            v.b    = pick_operand();
            v.prod = ref_prod(v.op, v.a, v.b);
            v.mode = ref_mode(v.op);
            run_op(v, $sformatf("rand%0d", i));
        end

        // MFHI held behind a multiply: stalled through DONE, released in the first IDLE cycle.
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd1000, 32'd3000);
        @(negedge clk);
        drive(1'b1, 3'b100, 32'd0, 32'd0);
        expect_run(64'd3000000, 2'b01, 1'b1, "mfhi");
        #1;
        chk("mfhi released stall", 64'(bus.o_stall), 64'd0);
        chk("mfhi released busy", 64'(bus.o_busy), 64'd0);
        @(negedge clk);
        #1;
        chk("mfhi not accepted", 64'(bus.o_busy), 64'd0);
        chk("mfhi no pulse", 64'(bus.o_hilo_mode), 64'd0);
        drive(1'b0, 3'b000, 32'd0, 32'd0);

        // Back-to-back: the held second multiply is accepted W+2 cycles after the first.
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd5, 32'd7);
        @(negedge clk);
        drive(1'b1, 3'b011, 32'd9, 32'd11);
        expect_run(64'd35, 2'b01, 1'b1, "b2b first");
        #1 chk("b2b gap stall", 64'(bus.o_stall), 64'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        expect_run(64'd99, 2'b10, 1'b0, "b2b second");

        // Flush at RUN iteration 10 abandons the multiply.
        @(negedge clk);
        drive(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        bus.i_flush = 1'b1;
        drive(1'b1, 3'b101, 32'd0, 32'd0);
        #1 chk("flush stall independent", 64'(bus.o_stall), 64'd1);
        @(negedge clk);
        bus.i_flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        #1 chk("flush busy", 64'(bus.o_busy), 64'd0);
        for (int c = 0; c < 26; c++) begin
            #1 chk("flush no pulse", 64'(bus.o_hilo_mode), 64'd0);
            @(negedge clk);
        end

        // Flush in IDLE blocks a same-cycle op.
        drive(1'b1, 3'b001, 32'd3, 32'd4);
        bus.i_flush = 1'b1;
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        bus.i_flush = 1'b0;
        #1 chk("idle flush not accepted", 64'(bus.o_busy), 64'd0);

        // Reset on the last RUN iteration suppresses the DONE pulse.
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd3, 32'd4);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (31) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset-run mode", 64'(bus.o_hilo_mode), 64'd0);
        chk("reset-run busy", 64'(bus.o_busy), 64'd0);

        // Reset in DONE: the pulse visible in DONE does not repeat after reset.
        @(negedge clk);
        drive(1'b1, 3'b010, 32'hFFFF_FFFE, 32'd4);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (32) @(negedge clk);
        #1 chk("done mode before reset", 64'(bus.o_hilo_mode), 64'd1);
        chk("done product before reset", bus.o_product, 64'hFFFF_FFFF_FFFF_FFF8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset-done mode", 64'(bus.o_hilo_mode), 64'd0);
        chk("reset-done busy", 64'(bus.o_busy), 64'd0);
        chk("reset-done product", bus.o_product, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the HI/LO multiply path of the 5-stage pipelined CPU. It accepts MULT/MULTU/MADDU operations from the EX stage and runs a 32-iteration shift-add multiplier. When the product is ready it issues a one-cycle load or accumulate command to the HiLo register. While the multiplier is busy it stalls any further multiply or MFHI/MFLO instruction so HI/LO is never read stale.

## Interface
Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clock clk
- op_valid  in  1  EX stage presents an operation this cycle
- op  in  3  operation code: 001 MULTU, 010 MULT (signed), 011 MADDU (unsigned, accumulate), 100 MFHI, 101 MFLO; other codes are no-ops
- rs_val  in  WIDTH  multiplicand
- rt_val  in  WIDTH  multiplier
- flush  in  1  pipeline flush; cancels an in-progress multiply
- stall  out  1  hold the EX stage (combinational)
- busy  out  1  multiply in progress (states RUN or DONE)
- hilo_mode  out  2  HiLo command: 00 none, 01 load, 10 accumulate (one-cycle pulse)
- product  out  2*WIDTH  result presented to the HiLo write port; valid when hilo_mode != 00

## Operation
States:
- IDLE
  - On op_valid with op in {001, 010, 011} and flush=0, latch the operands and the op, clear the accumulator, set count=0, and go to RUN.
  - MFHI/MFLO and unknown codes leave the state unchanged.
- RUN
  - Each cycle: if the multiplier LSB is 1, add the multiplicand (shifted left by count) into the 2*WIDTH accumulator.
  - Shift the multiplier right by one and increment count.
  - After iteration WIDTH-1, go to DONE.
- DONE
  - Drive product and hilo_mode for exactly one cycle, then return to IDLE.

Signed MULT:
- Operands are replaced by their magnitudes at latch time; the sign flag is rs[msb] XOR rt[msb].
- The product is two's-complement negated in DONE when the sign flag is set.
- The magnitude of the most negative value is 2^(WIDTH-1), treated as unsigned; no overflow.

HiLo command:
- hilo_mode = 01 for MULT/MULTU and 10 for MADDU.
- The addition for MADDU is performed inside HiLo, not in this block.

Stall:
- stall = op_valid AND (state != IDLE), for any op code, including MFHI/MFLO and unknown codes.
- Ops presented while busy are not accepted. The pipeline must hold them until stall drops.
- stall does not depend on flush.

Flush:
- In RUN: return to IDLE next cycle. No HiLo command is issued and the accumulator is discarded.
- In DONE: ignored; the write completes.
- In IDLE: blocks acceptance of a same-cycle op.

Reset:
- All state clears, state=IDLE, count=0.
- stall, busy, hilo_mode and product are 0.
- Reset mid-RUN or in DONE aborts the operation with no HiLo command.

Outputs outside DONE:
- product is 0 and hilo_mode is 00 in every cycle except DONE.

## Timing
- Op accepted at edge T (end of cycle T-1 in IDLE with op_valid high).
- Cycles T..T+WIDTH-1 are RUN. The cycle beginning at edge T+WIDTH is DONE; HiLo captures product at edge T+WIDTH+1.
- Total latency from acceptance to HiLo update is WIDTH+1 edges (33 for WIDTH=32).
- busy is high for WIDTH+1 cycles and low in the cycle following DONE.
- An MFHI issued during RUN or DONE stalls and is released in the first IDLE cycle, so it reads the updated HI.
- Back-to-back multiplies: the second is accepted in the first IDLE cycle after DONE, giving a minimum spacing of WIDTH+2 cycles between acceptances.
- The count register is 6 bits for WIDTH=32 (general form: clog2(WIDTH)+1 bits) and does not wrap during RUN.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - product = 0xFFFFFFFE_00000001 with hilo_mode=01 exactly 33 edges after acceptance.
  - busy high for 33 cycles.
- MULT -3 × 5 → product 0xFFFFFFFF_FFFFFFF1, mode 01.
- MULT 0x80000000 × 0x80000000 → product 0x40000000_00000000.
- MADDU 7 × 6 → product 0x2A, mode 10.
- MFHI presented on the cycle after acceptance:
  - stall stays high through DONE.
  - stall drops in the first IDLE cycle.
  - No spurious hilo_mode pulse.
- Abort cases:
  - flush asserted at RUN iteration 10 → IDLE next cycle, hilo_mode stays 00, busy low.
  - reset asserted in DONE → hilo_mode 00 on the following cycle.
  - op_valid with flush in IDLE → not accepted.
